// File: rtl/in_buffer_6_pkg.sv
// Shared NoC definitions: flit geometry, field positions and the input-buffer FSM encoding.
package in_buffer_6_pkg;

  localparam int FLIT_W   = 67;
  localparam int HDR_BIT  = 66;
  localparam int TAIL_BIT = 65;
  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 3;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

endpackage

// File: rtl/in_buffer_6_noc_fifo.sv
// Circular flit store with wrap-around pointers and an occupancy counter; head is read from storage only.
module noc_fifo #(
  parameter int DEPTH  = 6,
  parameter int FLIT_W = 67
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] wdata,
  input  logic              pop,
  output logic [FLIT_W-1:0] rdata,
  output logic [2:0]        count,
  output logic              full,
  output logic              empty
);
  import in_buffer_6_pkg::*;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 3'd1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 3'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/in_buffer_6.sv
// NoC input buffer: queues upstream flits, requests the switch for each packet head and forwards it flit by flit.
module in_buffer_6 #(
  parameter int DEPTH  = 6,
  parameter int FLIT_W = 67
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] FLIT_in,
  input  logic              VALID_in,
  output logic              BWDAUX1_out,
  output logic              BWDAUX2_out,
  output logic              BWDAUX3_out,
  output logic              req_valid,
  output logic [2:0]        req_dest,
  input  logic              gnt,
  output logic [FLIT_W-1:0] data_out,
  output logic              data_valid,
  input  logic              rd,
  output logic              drop
);
  import in_buffer_6_pkg::*;

  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  state_t            state;
  state_t            state_nxt;

  // Stall depends only on registered occupancy, so upstream never sees a path from rd/gnt/VALID_in.
  assign push        = VALID_in && !full;
  assign BWDAUX1_out = full;
  assign BWDAUX2_out = 1'b0;
  assign BWDAUX3_out = 1'b0;
  assign data_out    = head;

  noc_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (FLIT_in),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    drop       = 1'b0;
    req_valid  = 1'b0;
    req_dest   = '0;
    data_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        // Orphan body flits at the head can never be routed, so they are discarded here.
        if (!empty) begin
          if (head[HDR_BIT]) begin
            state_nxt = ST_REQ;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      ST_REQ: begin
        req_valid = 1'b1;
        req_dest  = head[DEST_LSB +: DEST_W];
        if (gnt) state_nxt = ST_FWD;
      end
      ST_FWD: begin
        data_valid = (count != '0);
        if (data_valid && rd) begin
          pop = 1'b1;
          if (head[TAIL_BIT]) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
